maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
- Streaming 1-D max-pool stage placed directly downstream of a net_* convolution chain, e.g. net_64_33_9_10_16_14.
- Consumes that net's signed T-bit output stream, one frame of L values per input vector. Default L=15 = 64-33-9-10+3.
- Emits the maximum of each non-overlapping window of P values. Output is buffered in a small FIFO.
- Uses the same valid/ready handshake on both sides as the net_* modules, so it chains directly.

Parameters:
- T, 16, data width in bits, signed two's complement.
- L, 15, values per frame; the window counter restarts at every frame boundary.
- P, 2, pooling window size, equal to the stride; P>=2.
- DEPTH, 2, output FIFO entries; DEPTH>=2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- x_data  in  T  signed input sample.
- x_valid  in  1  input sample valid.
- x_ready  out  1  block accepts a sample this cycle.
- y_data  out  T  signed pooled output, head of FIFO.
- y_valid  out  1  FIFO non-empty.
- y_ready  in  1  downstream accepts y_data.

Behaviour:
- Reset is synchronous: one clock edge with reset=1 clears every register.
  - Cleared state: idx=0, w=0, running max=0, FIFO empty.
  - Outputs in and immediately after reset: y_valid=0; x_ready=0 while reset=1.
  - Reset asserted mid-frame or mid-window discards the partial window and all FIFO contents; the next accepted sample is idx 0.
- Input handshake:
  - A sample transfers on a rising edge with x_valid && x_ready.
  - x_ready = !reset && (count < DEPTH), where count is the FIFO occupancy.
  - x_ready depends only on registered state. There is no combinational path from y_ready to x_ready, so a full FIFO blocks input even in a cycle where y_ready=1.
- Output handshake:
  - A result transfers on a rising edge with y_valid && y_ready.
  - y_data/y_valid reflect the FIFO head and are held stable while y_valid && !y_ready.
- Counters:
  - idx counts 0..L-1 within the frame; w counts 0..P-1 within the window.
  - On each accepted sample: idx wraps to 0 after L-1; w resets to 0 when it reaches P-1 or when idx==L-1.
- Max datapath:
  - On an accepted sample with w==0, max <= x_data; otherwise max <= (x_data > max ? x_data : max).
  - Comparison is signed T-bit and ties keep either value (they are equal). No widening or saturation is needed.
- Push rule:
  - When the accepted sample has w==P-1 or idx==L-1, the final max is written into the FIFO tail in that same edge.
  - The pushed value is max(max, x_data) computed combinationally, or x_data alone if w==0.
  - Partial trailing windows (L mod P != 0) therefore emit one output covering the remaining samples.
  - Outputs per frame = ceil(L/P); defaults give 8.
- Latency: the completing sample accepted at edge k gives y_valid=1 with that value in the cycle after edge k, if the FIFO was empty.
- Push and pop in the same edge: count unchanged, both pointers advance. Push cannot occur when full because x_ready=0.
- Throughput: one sample per cycle sustained while the downstream keeps y_ready=1.
- FIFO: circular buffer with read/write pointers wrapping mod DEPTH and a separate count register 0..DEPTH.
- Steady-state control is only the counters and FIFO occupancy; no other state machine is required.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- When defined, each value written to the FIFO is ReLU'd: negative values (MSB=1) become 0, non-negative values pass unchanged. The ReLU is applied after the max and adds no latency.
- When undefined, pooled values are written unmodified, including negatives.

Test Plan:
- Reset then one frame, L=15, P=2, continuous valid/ready, inputs 1,5,-3,-7,8,8,0,2,9,-1,4,4,-2,6,3 -> outputs 5,-3,8,2,9,4,6,3 with first y_valid one cycle after the second sample; with MAXPOOL_RELU_EN -> 5,0,8,2,9,4,6,3.
- Signed extremes: pairs (0x8000,0x7FFF), (0xFFFF,0x0001), (0x8000,0x8000) -> 0x7FFF, 0x0001, 0x8000 (no unsigned compare).
- Backpressure: y_ready=0 for 10 cycles while driving 8 samples -> x_ready falls after DEPTH=2 results queue; held y_data stable; releasing y_ready drains 5,-3 in order and input resumes; no loss or duplication.
- Frame boundary: two back-to-back frames of 15 values each equal to its index (0..14) -> 1,3,5,7,9,11,13,14 twice; the trailing single 14 never pairs with the next frame's 0.
- Reset mid-window: accept 7, assert reset for one edge, then send 2,3 -> single output 3; 7 never appears and y_valid is 0 during and right after reset.
- Random x_valid/y_ready toggling, randomized per cycle as in the net_* benches, over 156 frames with a reference-model compare -> 1248 outputs, 0 errors.

Source files
------------

// File: rtl/maxpool_stream.sv
// rtl/maxpool_stream.sv - streaming 1-D max-pool with output FIFO; optional ReLU via MAXPOOL_RELU_EN
module maxpool_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_FULL);
  assign head      = mem[rd_ptr];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && not_empty;

  // Circular buffer: pointers wrap at DEPTH-1 so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module maxpool_stream #(
  parameter int T     = 16,
  parameter int L     = 15,
  parameter int P     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int WW = $clog2(P);
  localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(P - 1);

  logic [IW-1:0]         idx_q;
  logic [WW-1:0]         w_q;
  logic signed [T-1:0]   max_q;
  logic signed [T-1:0]   x_s;
  logic signed [T-1:0]   pool_max;
  logic [T-1:0]          push_val;
  logic                  accept;
  logic                  win_done;
  logic                  fifo_full;

  assign x_s      = x_data;
  assign x_ready  = !reset && !fifo_full;
  assign accept   = x_valid && x_ready;
  assign win_done = (w_q == W_LAST) || (idx_q == IDX_LAST);

  // Running max including the current sample; the first sample of a window starts fresh.
  always_comb begin
    pool_max = max_q;
    if (w_q == '0 || x_s > max_q) pool_max = x_s;
  end

`ifdef MAXPOOL_RELU_EN
  assign push_val = pool_max[T-1] ? '0 : pool_max;
`else
  assign push_val = pool_max;
`endif

  // Frame and window counters plus the running max, advanced on each accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      w_q   <= '0;
      max_q <= '0;
    end else if (accept) begin
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      w_q   <= win_done ? '0 : w_q + 1'b1;
      max_q <= pool_max;
    end
  end

  maxpool_fifo #(
    .W     (T),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept && win_done),
    .push_data (push_val),
    .pop       (y_ready),
    .head      (y_data),
    .not_empty (y_valid),
    .full      (fifo_full)
  );
endmodule

// File: tb/tb_maxpool_stream.sv
// tb/tb_maxpool_stream.sv - self-checking bench for maxpool_stream
module tb_maxpool_stream;
  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] x_data = '0;
  logic        x_valid = 0;
  logic        x_ready;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready = 1;

  int          errors = 0;
  int          checks = 0;
  int          yr_mode = 0;
  int          acc_cnt = 0;
  logic [15:0] src_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  maxpool_stream #(.T(16), .L(15), .P(2), .DEPTH(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // y_ready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    forever begin
      @(posedge clk); #1;
      y_ready = (yr_mode == 0) ? 1'b1 : (yr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Record every output transfer; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset && y_valid && y_ready) got_q.push_back(y_data);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; x_valid = 0;
    @(negedge clk); #1;
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_x_ready", 32'(x_ready), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk); #1;
    check("post_rst_y_valid", 32'(y_valid), 32'd0);
    check("post_rst_x_ready", 32'(x_ready), 32'd1);
    got_q.delete(); exp_q.delete(); acc_cnt = 0;
  endtask

  task automatic run_src(input int rnd_v, input int budget);
    int cyc = 0;
    while (src_q.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      x_valid = rnd_v ? 1'($urandom_range(0, 1)) : 1'b1;
      x_data  = src_q[0];
      @(negedge clk);
      if (x_valid && x_ready) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    x_valid = 0;
    if (src_q.size() != 0) check("src_timeout", 32'(src_q.size()), 32'd0);
  endtask

  task automatic compare_out(input string tag, input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_idle"}, 32'(y_valid), 32'd0);
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[15] ? 16'h0 : v;
`else
    return v;
`endif
  endfunction

  // Reference: chunk each 15-sample frame into windows of 2, trailing single kept.
  task automatic model_frames(input logic [15:0] s[$]);
    for (int f = 0; f + 15 <= s.size(); f += 15) begin
      for (int j = 0; j < 15; j += 2) begin
        logic signed [15:0] m;
        m = s[f + j];
        if (j + 1 < 15 && $signed(s[f + j + 1]) > m) m = s[f + j + 1];
        exp_q.push_back(relu(m));
      end
    end
  endtask

  initial begin
    logic [15:0] frame1[$];
    logic [15:0] tmp[$];

    // Test 1: one frame, continuous handshake, first-output latency
    do_reset();
    frame1 = '{16'd1, 16'd5, -16'sd3, -16'sd7, 16'd8, 16'd8, 16'd0, 16'd2,
               16'd9, -16'sd1, 16'd4, 16'd4, -16'sd2, 16'd6, 16'd3};
    src_q = frame1;
    fork
      run_src(0, 200);
      begin
        @(negedge clk); #2;
        check("lat_s0_y_valid", 32'(y_valid), 32'd0);
        @(negedge clk); #2;
        check("lat_s1_y_valid", 32'(y_valid), 32'd0);
        @(negedge clk); #2;
        check("lat_first_y_valid", 32'(y_valid), 32'd1);
        check("lat_first_y_data", 32'(y_data), 32'd5);
      end
    join
`ifdef MAXPOOL_RELU_EN
    exp_q = '{16'd5, 16'd0, 16'd8, 16'd2, 16'd9, 16'd4, 16'd6, 16'd3};
`else
    exp_q = '{16'd5, 16'hFFFD, 16'd8, 16'd2, 16'd9, 16'd4, 16'd6, 16'd3};
`endif
    compare_out("frame1", 200);

    // Test 2: signed extremes
    do_reset();
    src_q = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000};
    run_src(0, 200);
`ifdef MAXPOOL_RELU_EN
    exp_q = '{16'h7FFF, 16'h0001, 16'h0000};
`else
    exp_q = '{16'h7FFF, 16'h0001, 16'h8000};
`endif
    compare_out("extremes", 200);

    // Test 3: backpressure with FIFO full
    do_reset();
    yr_mode = 2;
    src_q = '{16'd1, 16'd5, -16'sd3, -16'sd7, 16'd8, 16'd8, 16'd0, 16'd2};
    fork
      run_src(0, 400);
      begin
        for (int c = 1; c <= 10; c++) begin
          @(negedge clk); #2;
          if (c == 5 || c == 10) begin
            check("bp_x_ready", 32'(x_ready), 32'd0);
            check("bp_y_valid", 32'(y_valid), 32'd1);
            check("bp_y_data_held", 32'(y_data), 32'd5);
            check("bp_accepted", 32'(acc_cnt), 32'd4);
          end
        end
        yr_mode = 0;
      end
    join
`ifdef MAXPOOL_RELU_EN
    exp_q = '{16'd5, 16'd0, 16'd8, 16'd2};
`else
    exp_q = '{16'd5, 16'hFFFD, 16'd8, 16'd2};
`endif
    compare_out("backpressure", 200);

    // Test 4: frame boundary, two frames of index values
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 15; i++) src_q.push_back(16'(i));
    run_src(0, 400);
    for (int k = 0; k < 2; k++)
      exp_q = {exp_q, 16'd1, 16'd3, 16'd5, 16'd7, 16'd9, 16'd11, 16'd13, 16'd14};
    compare_out("boundary", 200);

    // Test 5: reset mid-window discards the partial max
    do_reset();
    src_q = '{16'd7};
    run_src(0, 50);
    do_reset();
    src_q = '{16'd2, 16'd3};
    run_src(0, 50);
    exp_q = '{16'd3};
    compare_out("mid_reset", 100);

    // Test 6: random handshakes over 156 frames against the reference model
    do_reset();
    yr_mode = 1;
    tmp.delete();
    for (int i = 0; i < 156 * 15; i++) begin
      case ($urandom_range(0, 9))
        0:       tmp.push_back(16'h8000);
        1:       tmp.push_back(16'h7FFF);
        default: tmp.push_back(16'($urandom));
      endcase
    end
    src_q = tmp;
    model_frames(tmp);
    run_src(1, 40000);
    yr_mode = 0;
    compare_out("random", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
